// File: rtl/mult_unit.sv
// mult_unit: multi-cycle 32x32->64 shift-add multiplier with architectural HI/LO registers
module thirty_two_bit_full_adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        carry_in,
   output logic [31:0] sum,
   output logic        carry_out
);
   assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};
endmodule

module mult_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, next_state;
   logic [31:0] p_hi, p_lo, mcand, addend, sum;
   logic        carry_out, neg_flag;
   logic [4:0]  cnt;
   logic [63:0] fixed;
   assign addend = p_lo[0] ? mcand : 32'd0;
   thirty_two_bit_full_adder u_add (
      .a(p_hi), .b(addend), .carry_in(1'b0), .sum(sum), .carry_out(carry_out)
   );
   // next state, status outputs and sign-corrected product
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CALC;
         CALC:    if (cnt == 5'd31) next_state = FIX;
         FIX:     next_state = DONE;
         default: next_state = IDLE;
      endcase
      busy  = (state == CALC) || (state == FIX);
      done  = (state == DONE);
      fixed = neg_flag ? ~{p_hi, p_lo} + 64'd1 : {p_hi, p_lo};
   end
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end
   // operand load, shift-add iterations, sign fix and HI/LO writes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_hi     <= '0;
         p_lo     <= '0;
         mcand    <= '0;
         neg_flag <= 1'b0;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mthi) hi <= wdata;
               if (mtlo) lo <= wdata;
               if (start) begin
                  mcand    <= (is_signed && a[31]) ? -a : a;
                  p_lo     <= (is_signed && b[31]) ? -b : b;
                  p_hi     <= '0;
                  cnt      <= '0;
                  neg_flag <= is_signed & (a[31] ^ b[31]);
               end
            end
            CALC: begin
               {p_hi, p_lo} <= {carry_out, sum, p_lo[31:1]};
               cnt          <= cnt + 5'd1;
            end
            FIX: begin
               {p_hi, p_lo} <= fixed;
               {hi, lo}     <= fixed;
            end
            default: ;
         endcase
      end
   end
endmodule
